cam_exp_search_ctrl: RTL and testbench
======================================

Name: cam_exp_search_ctrl

Overview:
Sequencer that runs a multi-bit exact-match key search on one CAM_Subarray_Exp column group. The key is stored bit-sliced: bit i of every word lives in row BASE_ROW+i. The block issues paired-row compare ops (mode 3'b100), AND-accumulates the returned tags into a 32-bit match mask, and can write that mask back into a result row. It sits between the search requester and a single subarray, and is the only driver of that subarray's control pins.

Parameters:
KEY_BITS, 8, key width in bits; even, 2..16.
BASE_ROW, 0, cmp-space row holding key bit 0; BASE_ROW+KEY_BITS-1 must be ≤ 31.
RESULT_ROW, 31, cmp-space row for write-back; must lie outside the key rows.
- Any parameter violation is an elaboration error (generate-time check).

Ports:
CLK  in  1  clock
RSTN  in  1  synchronous active-low reset
start  in  1  request pulse; accepted only in IDLE
key  in  KEY_BITS  search key, sampled on accept
wb_en  in  1  write the final mask to RESULT_ROW, sampled on accept
busy  out  1  high from the cycle after accept through the DONE cycle
done  out  1  one-cycle pulse; results valid from this cycle
match_mask  out  32  registered result mask, held until the next accept
match_any  out  1  OR-reduction of match_mask
match_count  out  6  popcount of match_mask (0..32)
cam_chip_enable  out  1  subarray chip_enable
cam_operation_mode  out  3  subarray operation_mode
cam_cmp_addr  out  10  subarray cmp_addr
cam_cmp_data  out  2  subarray cmp_data
cam_addr_select  out  1  always 0 (cmp space)
cam_acc_en  out  1  always 0
cam_update_signal  out  1  subarray update_signal
cam_tag_in  out  32  subarray tag_in (write mask)
cam_ppg_addr / cam_ppg_data / cam_data_in  out  6/2/32  tied 0
cam_tag_out  in  32  subarray tag_out; valid one cycle after a compare op is issued

Behaviour:
- Reset (RSTN=0 at a CLK edge): state=IDLE, all outputs 0, match_mask=0, internal acc=all ones.
- Reset mid-operation aborts immediately. The subarray sees chip_enable=0 from the next cycle.
- FSM states: IDLE, ISSUE, DRAIN, WB_CLR, WB_SET, DONE. P = KEY_BITS/2.
- IDLE:
  - cam_chip_enable=0.
  - On start=1: latch key and wb_en, set acc=32'hFFFFFFFF, set pair index p=0, go to ISSUE.
- ISSUE (one cycle per pair):
  - cam_chip_enable=1, mode=3'b100.
  - cmp_addr[4:0]=BASE_ROW+2p, cmp_addr[9:5]=BASE_ROW+2p+1.
  - cmp_data={key[2p+1],key[2p]}.
  - p increments each cycle. After p=P-1, go to DRAIN.
- Tag capture: a registered issue-valid flag delays by one cycle. In any cycle where the flag is 1, acc <= acc & cam_tag_out.
- DRAIN: cam_chip_enable=0; captures the final in-flight tag. Next state is WB_CLR if wb_en is latched, else DONE.
- WB_CLR: mode=3'b001, cmp_addr[4:0]=RESULT_ROW, tag_in=~acc, update_signal=0. Clears non-matching bits.
- WB_SET: same as WB_CLR but tag_in=acc, update_signal=1. Sets matching bits. Then go to DONE.
- DONE:
  - done=1. match_mask, match_any and match_count are registered from acc on entry to DONE.
  - cam_chip_enable=0. Go to IDLE.
- Latency: start is accepted at cycle 0.
  - done asserts at cycle P+2 without write-back, or P+4 with write-back.
  - KEY_BITS=8 gives done at cycle 6 or 8.
- start while busy is ignored (no queueing). start in the DONE cycle is ignored. start in the cycle after DONE (back in IDLE) is accepted.
- If acc becomes 0 the block still completes all pairs (unless the optional feature below is enabled).
- If acc is 0 with wb_en: WB_SET runs with tag_in=0 (a no-op write), and the result row ends all zero.
- Key changes after accept have no effect.

Optional Feature:
CAM_EARLY_EXIT_EN
- Defined: in ISSUE, if a captured tag makes (acc & cam_tag_out)==0, stop issuing and go to DRAIN (the in-flight tag is still captured and ANDed). done asserts earlier, and write-back still runs if wb_en is latched.
- Undefined: all P pairs are always issued and latency is fixed.

Test Plan:
- KEY_BITS=8, BASE_ROW=0. CAM model rows set so that only word bits 3 and 17 hold 0xA5 bit-sliced. start with key=8'hA5, wb_en=0 -> 4 mode-100 ops on rows (0,1),(2,3),(4,5),(6,7); done at cycle 6; match_mask=32'h00020008, match_count=2, match_any=1.
- Same setup, wb_en=1, RESULT_ROW preloaded 32'hFFFFFFFF -> WB_CLR tag_in=32'hFFFDFFF7 with update=0, then WB_SET tag_in=32'h00020008 with update=1; row 31 reads 32'h00020008; done at cycle 8.
- key=8'h00 with no matching words -> match_mask=0, match_any=0, match_count=0. With CAM_EARLY_EXIT_EN, when the first tag is 0: only 2 ops issue and done arrives at cycle 4.
- start pulsed again at cycles 2 and 6 of a running search -> both ignored, busy stays 1, and the first result is unchanged. start at cycle 7 (IDLE) -> accepted.
- RSTN=0 asserted in the 2nd ISSUE cycle -> next cycle: cam_chip_enable=0, busy=0, done=0, match_mask=0. A new search after release gives correct results.
- All 32 words match key 8'hFF -> match_mask=32'hFFFFFFFF, match_count=32 (6'b100000).

Source files
------------

// File: rtl/cam_exp_search_ctrl.sv
// Purpose : sequences a bit-sliced exact-match key search on one CAM_Subarray_Exp
//           column group. It issues paired-row compares, AND-accumulates the tags
//           into a 32-bit match mask and can write that mask back to a result row.
// Latency : done at cycle P+2 after accept (P = KEY_BITS/2), or P+4 with write-back.
//           With CAM_EARLY_EXIT_EN defined, issue stops as soon as the mask is empty.
// Backpressure: none. start is a pulse and is only taken in IDLE; starts that
//           arrive while busy or in the DONE cycle are dropped, not queued.
//
// Optional feature macro: CAM_EARLY_EXIT_EN (early exit on an all-zero mask).
//
// Ports:
//   CLK, RSTN                       clock and synchronous active-low reset
//   start, key, wb_en               search request (key and wb_en sampled on accept)
//   busy, done                      status (busy cycle after accept through DONE)
//   match_mask/any/count            registered results, updated on entry to DONE
//   cam_*                           subarray control pins (this block is the only driver)
//   cam_tag_out                     subarray tags, valid one cycle after a compare
module cam_exp_search_ctrl #(
  parameter int KEY_BITS   = 8,
  parameter int BASE_ROW   = 0,
  parameter int RESULT_ROW = 31
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key,
  input  logic                wb_en,
  output logic                busy,
  output logic                done,
  output logic [31:0]         match_mask,
  output logic                match_any,
  output logic [5:0]          match_count,
  output logic                cam_chip_enable,
  output logic [2:0]          cam_operation_mode,
  output logic [9:0]          cam_cmp_addr,
  output logic [1:0]          cam_cmp_data,
  output logic                cam_addr_select,
  output logic                cam_acc_en,
  output logic                cam_update_signal,
  output logic [31:0]         cam_tag_in,
  output logic [5:0]          cam_ppg_addr,
  output logic [1:0]          cam_ppg_data,
  output logic [31:0]         cam_data_in,
  input  logic [31:0]         cam_tag_out
);

  // Elaboration-time parameter checks
  if ((KEY_BITS < 2) || (KEY_BITS > 16) || ((KEY_BITS % 2) != 0)) begin : g_err_key_bits
    $error("cam_exp_search_ctrl: KEY_BITS must be even and in 2..16");
  end
  if ((BASE_ROW < 0) || (BASE_ROW + KEY_BITS - 1 > 31)) begin : g_err_base_row
    $error("cam_exp_search_ctrl: key rows must lie within rows 0..31");
  end
  if ((RESULT_ROW < 0) || (RESULT_ROW > 31) ||
      ((RESULT_ROW >= BASE_ROW) && (RESULT_ROW <= BASE_ROW + KEY_BITS - 1))) begin : g_err_result_row
    $error("cam_exp_search_ctrl: RESULT_ROW must be 0..31 and outside the key rows");
  end

  localparam logic [4:0] BASE5  = 5'(BASE_ROW);
  localparam logic [4:0] RES5   = 5'(RESULT_ROW);
  localparam logic [3:0] LAST_P = 4'(KEY_BITS / 2 - 1);

  localparam logic [2:0] MODE_CMP = 3'b100;
  localparam logic [2:0] MODE_WR  = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WB_CLR,
    S_WB_SET,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [KEY_BITS-1:0] r_key;
  logic                r_wb;
  logic [3:0]          r_p;       // pair currently on the subarray pins
  logic                r_iss_vld; // a compare was issued last cycle; its tag is on cam_tag_out
  logic [31:0]         r_acc;

  logic [31:0]         w_acc_nxt;
  logic [3:0]          w_pair;
  logic [KEY_BITS-1:0] w_src_key;
  logic [KEY_BITS-1:0] w_kshift;
  logic [4:0]          w_row_lo;
  logic [4:0]          w_row_hi;
  logic [5:0]          w_popcnt;
  logic                w_early;

  // Pin-driving outputs are registered, so everything below describes the
  // pair that will be on the pins in the *next* cycle.
  always_comb begin
    w_acc_nxt = r_iss_vld ? (r_acc & cam_tag_out) : r_acc;
    w_pair    = (r_state == S_IDLE) ? 4'd0 : (r_p + 4'd1);
    w_src_key = (r_state == S_IDLE) ? key : r_key;
    w_kshift  = w_src_key >> {w_pair, 1'b0};
    w_row_lo  = BASE5 + {w_pair, 1'b0};
    w_row_hi  = w_row_lo + 5'd1;
    w_popcnt  = '0;
    for (int i = 0; i < 32; i++) begin
      w_popcnt = w_popcnt + 6'(w_acc_nxt[i]);
    end
  end

`ifdef CAM_EARLY_EXIT_EN
  // An empty mask can never recover under AND, so further compares are wasted.
  assign w_early = r_iss_vld && (w_acc_nxt == '0);
`else
  assign w_early = 1'b0;
`endif

  assign cam_addr_select = 1'b0;
  assign cam_acc_en      = 1'b0;
  assign cam_ppg_addr    = '0;
  assign cam_ppg_data    = '0;
  assign cam_data_in     = '0;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state            <= S_IDLE;
      r_key              <= '0;
      r_wb               <= 1'b0;
      r_p                <= '0;
      r_iss_vld          <= 1'b0;
      r_acc              <= '1;
      busy               <= 1'b0;
      done               <= 1'b0;
      match_mask         <= '0;
      match_any          <= 1'b0;
      match_count        <= '0;
      cam_chip_enable    <= 1'b0;
      cam_operation_mode <= '0;
      cam_cmp_addr       <= '0;
      cam_cmp_data       <= '0;
      cam_update_signal  <= 1'b0;
      cam_tag_in         <= '0;
    end else begin
      r_iss_vld          <= (r_state == S_ISSUE);
      r_acc              <= w_acc_nxt;
      done               <= 1'b0;
      cam_chip_enable    <= 1'b0;
      cam_operation_mode <= '0;
      cam_cmp_addr       <= '0;
      cam_cmp_data       <= '0;
      cam_update_signal  <= 1'b0;
      cam_tag_in         <= '0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key              <= key;
            r_wb               <= wb_en;
            r_acc              <= '1;
            r_p                <= '0;
            busy               <= 1'b1;
            r_state            <= S_ISSUE;
            cam_chip_enable    <= 1'b1;
            cam_operation_mode <= MODE_CMP;
            cam_cmp_addr       <= {w_row_hi, w_row_lo};
            cam_cmp_data       <= w_kshift[1:0];
          end
        end

        S_ISSUE: begin
          if ((r_p == LAST_P) || w_early) begin
            r_state <= S_DRAIN;
          end else begin
            r_p                <= w_pair;
            cam_chip_enable    <= 1'b1;
            cam_operation_mode <= MODE_CMP;
            cam_cmp_addr       <= {w_row_hi, w_row_lo};
            cam_cmp_data       <= w_kshift[1:0];
          end
        end

        S_DRAIN: begin
          if (r_wb) begin
            // Two-step write-back: clear the non-matching bits, then set the matching ones.
            r_state            <= S_WB_CLR;
            cam_chip_enable    <= 1'b1;
            cam_operation_mode <= MODE_WR;
            cam_cmp_addr       <= {5'd0, RES5};
            cam_tag_in         <= ~w_acc_nxt;
            cam_update_signal  <= 1'b0;
          end else begin
            r_state     <= S_DONE;
            done        <= 1'b1;
            match_mask  <= w_acc_nxt;
            match_any   <= |w_acc_nxt;
            match_count <= w_popcnt;
          end
        end

        S_WB_CLR: begin
          r_state            <= S_WB_SET;
          cam_chip_enable    <= 1'b1;
          cam_operation_mode <= MODE_WR;
          cam_cmp_addr       <= {5'd0, RES5};
          cam_tag_in         <= w_acc_nxt;
          cam_update_signal  <= 1'b1;
        end

        S_WB_SET: begin
          r_state     <= S_DONE;
          done        <= 1'b1;
          match_mask  <= w_acc_nxt;
          match_any   <= |w_acc_nxt;
          match_count <= w_popcnt;
        end

        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_exp_search_ctrl.sv
// Purpose : scoreboard bench for cam_exp_search_ctrl with a behavioural subarray.
// Latency : expected done cycle is carried in each scoreboard entry.
// Backpressure: none; ignored starts are driven but never pushed.
module tb_cam_exp_search_ctrl;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        start;
  logic [7:0]  key;
  logic        wb_en;
  logic        busy;
  logic        done;
  logic [31:0] match_mask;
  logic        match_any;
  logic [5:0]  match_count;
  logic        cam_chip_enable;
  logic [2:0]  cam_operation_mode;
  logic [9:0]  cam_cmp_addr;
  logic [1:0]  cam_cmp_data;
  logic        cam_addr_select;
  logic        cam_acc_en;
  logic        cam_update_signal;
  logic [31:0] cam_tag_in;
  logic [5:0]  cam_ppg_addr;
  logic [1:0]  cam_ppg_data;
  logic [31:0] cam_data_in;
  logic [31:0] cam_tag_out;

  cam_exp_search_ctrl #(.KEY_BITS(8), .BASE_ROW(0), .RESULT_ROW(31)) dut (
    .CLK                (CLK),
    .RSTN               (RSTN),
    .start              (start),
    .key                (key),
    .wb_en              (wb_en),
    .busy               (busy),
    .done               (done),
    .match_mask         (match_mask),
    .match_any          (match_any),
    .match_count        (match_count),
    .cam_chip_enable    (cam_chip_enable),
    .cam_operation_mode (cam_operation_mode),
    .cam_cmp_addr       (cam_cmp_addr),
    .cam_cmp_data       (cam_cmp_data),
    .cam_addr_select    (cam_addr_select),
    .cam_acc_en         (cam_acc_en),
    .cam_update_signal  (cam_update_signal),
    .cam_tag_in         (cam_tag_in),
    .cam_ppg_addr       (cam_ppg_addr),
    .cam_ppg_data       (cam_ppg_data),
    .cam_data_in        (cam_data_in),
    .cam_tag_out        (cam_tag_out)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural subarray: bit-sliced rows, registered compare tags, masked writes.
  logic [31:0] cam_row [32];
  logic [31:0] ld_rows [32];
  logic        ld_req = 1'b0;

  always @(posedge CLK) begin
    if (ld_req) begin
      cam_row <= ld_rows;
    end else if (cam_chip_enable && cam_operation_mode == 3'b001) begin
      for (int w = 0; w < 32; w++)
        if (cam_tag_in[w]) cam_row[cam_cmp_addr[4:0]][w] <= cam_update_signal;
    end
    if (cam_chip_enable && cam_operation_mode == 3'b100) begin
      for (int w = 0; w < 32; w++)
        cam_tag_out[w] <= (cam_row[cam_cmp_addr[4:0]][w] == cam_cmp_data[0]) &&
                          (cam_row[cam_cmp_addr[9:5]][w] == cam_cmp_data[1]);
    end else begin
      cam_tag_out <= '0;
    end
  end

  typedef struct {
    logic [7:0]  key;
    logic [31:0] mask;
    logic [5:0]  cnt;
    logic        any;
    int          lat;
    int          ops;
    logic        wb;
    logic [31:0] clr;
    logic [31:0] row31;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_ops   = 0;
  int   n_wb    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: checks every subarray op and every done pulse against the front entry.
  always @(negedge CLK) begin
    if (!RSTN) begin
      n_ops = 0;
      n_wb  = 0;
    end else begin
      if (cam_chip_enable && cam_operation_mode == 3'b100) begin
        if (sb.size() == 0) begin
          chk("cmp_op_without_request", 32'd1, 32'd0);
        end else begin
          logic [7:0] ks;
          ks = sb[0].key >> (2 * n_ops);
          chk("cmp_addr", {22'd0, cam_cmp_addr}, {22'd0, 5'(2 * n_ops + 1), 5'(2 * n_ops)});
          chk("cmp_data", {30'd0, cam_cmp_data}, {30'd0, ks[1:0]});
          n_ops++;
        end
      end
      if (cam_chip_enable && cam_operation_mode == 3'b001) begin
        if (sb.size() == 0) begin
          chk("wr_op_without_request", 32'd1, 32'd0);
        end else begin
          chk("wb_row", {27'd0, cam_cmp_addr[4:0]}, 32'd31);
          if (n_wb == 0) begin
            chk("wb_clr_tag", cam_tag_in, sb[0].clr);
            chk("wb_clr_upd", {31'd0, cam_update_signal}, 32'd0);
          end else begin
            chk("wb_set_tag", cam_tag_in, sb[0].mask);
            chk("wb_set_upd", {31'd0, cam_update_signal}, 32'd1);
          end
          n_wb++;
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_without_request", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("match_mask", match_mask, e.mask);
          chk("match_count", {26'd0, match_count}, {26'd0, e.cnt});
          chk("match_any", {31'd0, match_any}, {31'd0, e.any});
          chk("done_latency", 32'(cyc - e.t0), 32'(e.lat));
          chk("cmp_op_count", 32'(n_ops), 32'(e.ops));
          chk("wb_op_count", 32'(n_wb), e.wb ? 32'd2 : 32'd0);
          if (e.wb) chk("result_row", cam_row[31], e.row31);
        end
        n_ops = 0;
        n_wb  = 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Words 3 and 17 hold v_match, all others v_other; rows 0..7 carry the key bits.
  task automatic load_words(input logic [7:0] v_match, input logic [7:0] v_other,
                            input logic [31:0] row31);
    for (int r = 0; r < 32; r++) ld_rows[r] = '0;
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 32; w++)
        ld_rows[i][w] = (w == 3 || w == 17) ? v_match[i] : v_other[i];
    ld_rows[31] = row31;
    ld_req = 1'b1;
    tick();
    ld_req = 1'b0;
  endtask

  task automatic issue(input logic [7:0] k, input logic wb, input logic [31:0] mask,
                       input logic [5:0] cnt, input logic any, input int lat, input int ops,
                       input logic [31:0] clr, input logic [31:0] row31);
    exp_t e;
    e.key = k; e.mask = mask; e.cnt = cnt; e.any = any; e.lat = lat; e.ops = ops;
    e.wb = wb; e.clr = clr; e.row31 = row31; e.t0 = cyc;
    sb.push_back(e);
    start = 1'b1; key = k; wb_en = wb;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done, expected done within 40 cycles");
      sb.delete();
    end
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    RSTN = 1'b0; start = 1'b0; key = '0; wb_en = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mask", match_mask, 32'd0);
    chk("rst_any_count", {25'd0, match_any, match_count}, 32'd0);
    chk("rst_ce_mode", {28'd0, cam_chip_enable, cam_operation_mode}, 32'd0);
    chk("rst_addr_upd", {21'd0, cam_update_signal, cam_cmp_addr}, 32'd0);
    chk("rst_tag_in", cam_tag_in, 32'd0);
    RSTN = 1'b1;
    tick();

    // Basic search, no write-back
    load_words(8'hA5, 8'h5A, 32'hFFFF_FFFF);
    issue(8'hA5, 1'b0, 32'h0002_0008, 6'd2, 1'b1, 6, 4, 32'h0, 32'h0);
    wait_idle();

    // Search with write-back into row 31
    issue(8'hA5, 1'b1, 32'h0002_0008, 6'd2, 1'b1, 8, 4, 32'hFFFD_FFF7, 32'h0002_0008);
    wait_idle();

    // No word matches key 0
`ifdef CAM_EARLY_EXIT_EN
    issue(8'h00, 1'b0, 32'h0, 6'd0, 1'b0, 4, 2, 32'h0, 32'h0);
`else
    issue(8'h00, 1'b0, 32'h0, 6'd0, 1'b0, 6, 4, 32'h0, 32'h0);
`endif
    wait_idle();

    // Empty mask with write-back: row 31 ends all zero
    load_words(8'hA5, 8'h5A, 32'hFFFF_FFFF);
`ifdef CAM_EARLY_EXIT_EN
    issue(8'h00, 1'b1, 32'h0, 6'd0, 1'b0, 6, 2, 32'hFFFF_FFFF, 32'h0);
`else
    issue(8'h00, 1'b1, 32'h0, 6'd0, 1'b0, 8, 4, 32'hFFFF_FFFF, 32'h0);
`endif
    wait_idle();

    // Starts at cycles 2 and 6 are dropped; start at cycle 7 is taken
    issue(8'hA5, 1'b0, 32'h0002_0008, 6'd2, 1'b1, 6, 4, 32'h0, 32'h0); // now cycle 1
    tick();                                                           // cycle 2
    start = 1'b1; key = 8'h00;
    chk("busy_at_c2", {31'd0, busy}, 32'd1);
    tick(); start = 1'b0;                                             // cycle 3
    tick(); tick(); tick();                                           // cycle 6
    start = 1'b1; key = 8'h00;
    chk("busy_at_c6", {31'd0, busy}, 32'd1);
    tick();                                                           // cycle 7
    issue(8'h5A, 1'b0, 32'hFFFD_FFF7, 6'd30, 1'b1, 6, 4, 32'h0, 32'h0);
    wait_idle();

    // Reset during the second ISSUE cycle aborts the search
    issue(8'hA5, 1'b0, 32'h0002_0008, 6'd2, 1'b1, 6, 4, 32'h0, 32'h0); // cycle 1
    tick();                                                           // cycle 2
    RSTN = 1'b0;
    tick();                                                           // cycle 3
    sb.delete();
    chk("abort_ce", {31'd0, cam_chip_enable}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_mask", match_mask, 32'd0);
    RSTN = 1'b1;
    tick(); tick();
    issue(8'hA5, 1'b0, 32'h0002_0008, 6'd2, 1'b1, 6, 4, 32'h0, 32'h0);
    wait_idle();

    // Every word matches
    load_words(8'hFF, 8'hFF, 32'h0);
    issue(8'hFF, 1'b0, 32'hFFFF_FFFF, 6'd32, 1'b1, 6, 4, 32'h0, 32'h0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
